// File: rtl/id_rf_pkg.sv
// Shared constants and helpers for the ID-stage register file and pending-write scoreboard.
package id_rf_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 5;
    localparam int DEFAULT_CNT_W  = 2;

    function automatic int maxCount(input int cntW);
        return (1 << cntW) - 1;
    endfunction

    // Low bit of element idx in a flattened vector of width-bit elements.
    function automatic int sliceLo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/sb_pending_cnt.sv
// One per-register pending-write counter: issue increments, write-backs decrement,
// flush clears; exposes the count net of this cycle's write-backs.
module sb_pending_cnt
    import id_rf_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W,
    parameter int DEC_W = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic [DEC_W-1:0] decCnt,
    input  logic             flush,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] eff,
    output logic             underflow
);

    localparam int SUM_W = ((CNT_W > DEC_W) ? CNT_W : DEC_W) + 1;

    logic [SUM_W-1:0] sumUp;
    logic [SUM_W-1:0] decExt;
    logic [SUM_W-1:0] cntExt;
    logic [SUM_W-1:0] nextVal;

    always_comb begin
        cntExt    = SUM_W'(cnt);
        sumUp     = cntExt + SUM_W'(inc);
        decExt    = SUM_W'(decCnt);
        underflow = decExt > sumUp;
        nextVal   = underflow ? '0 : (sumUp - decExt);
        eff       = (decExt >= cntExt) ? '0 : CNT_W'(cntExt - decExt);
    end

    // Issue logic never lets an increment land on a saturated counter without a
    // matching write-back, so the truncation below cannot wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else begin
            cnt <= CNT_W'(nextVal);
        end
    end

endmodule

// File: rtl/id_regfile_scoreboard.sv
// Decode-stage operand block: multi-port register file with WB->ID bypass and a
// per-register pending-write scoreboard producing the issue stall.
module id_regfile_scoreboard
    import id_rf_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int NUM_WB   = 1,
    parameter int CNT_W    = DEFAULT_CNT_W,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic [NUM_WB-1:0]        wb_en,
    input  logic [NUM_WB*ADDR_W-1:0] wb_addr,
    input  logic [NUM_WB*DATA_W-1:0] wb_data,
    input  logic                     issue_valid,
    input  logic                     issue_wr,
    input  logic [ADDR_W-1:0]        issue_dst,
    input  logic                     hold,
    input  logic                     flush_pending,
    output logic                     stall_out,
    output logic                     sb_err
);

    localparam int NREG  = 2 ** ADDR_W;
    localparam int DEC_W = $clog2(NUM_WB + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(maxCount(CNT_W));

    logic [DATA_W-1:0] regFile [NREG];
    logic [DEC_W-1:0]  decCnt  [NREG];
    logic [CNT_W-1:0]  cntArr  [NREG];
    logic [CNT_W-1:0]  effArr  [NREG];
    logic [NREG-1:0]   incVec;
    logic [NREG-1:0]   undfVec;

    logic [ADDR_W-1:0] rdAddrCur;
    logic [DATA_W-1:0] rdValCur;
    logic              rdIsZero;
    logic              srcHazard;
    logic              ovfHazard;
    logic              adv;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regFile[i] <= '0;
            end
        end else begin
            // Later ports overwrite earlier ones, so the highest port wins on a tie.
            for (int w = 0; w < NUM_WB; w++) begin
                if (wb_en[w] && !(ZERO_REG != 0 && wb_addr[sliceLo(w, ADDR_W) +: ADDR_W] == '0)) begin
                    regFile[wb_addr[sliceLo(w, ADDR_W) +: ADDR_W]] <= wb_data[sliceLo(w, DATA_W) +: DATA_W];
                end
            end
        end
    end

    always_comb begin
        rd_data   = '0;
        srcHazard = 1'b0;
        rdAddrCur = '0;
        rdValCur  = '0;
        rdIsZero  = 1'b0;
        for (int p = 0; p < NUM_RD; p++) begin
            rdAddrCur = rd_addr[sliceLo(p, ADDR_W) +: ADDR_W];
            rdIsZero  = (ZERO_REG != 0) && (rdAddrCur == '0);
            rdValCur  = regFile[rdAddrCur];
            for (int w = 0; w < NUM_WB; w++) begin
                if (wb_en[w] && wb_addr[sliceLo(w, ADDR_W) +: ADDR_W] == rdAddrCur) begin
                    rdValCur = wb_data[sliceLo(w, DATA_W) +: DATA_W];
                end
            end
            if (rdIsZero) begin
                rdValCur = '0;
            end
            rd_data[sliceLo(p, DATA_W) +: DATA_W] = rdValCur;
            if (rd_en[p] && !rdIsZero && effArr[rdAddrCur] != '0) begin
                srcHazard = 1'b1;
            end
        end
    end

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            decCnt[r] = '0;
            if (!(ZERO_REG != 0 && r == 0)) begin
                for (int w = 0; w < NUM_WB; w++) begin
                    if (wb_en[w] && wb_addr[sliceLo(w, ADDR_W) +: ADDR_W] == ADDR_W'(r)) begin
                        decCnt[r] = decCnt[r] + DEC_W'(1);
                    end
                end
            end
        end
    end

    assign ovfHazard = issue_wr && (cntArr[issue_dst] == CNT_MAX) && (decCnt[issue_dst] == '0);
    assign stall_out = issue_valid && (srcHazard || ovfHazard);
    assign adv       = issue_valid && !stall_out && !hold;

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            incVec[r] = adv && issue_wr && (issue_dst == ADDR_W'(r)) && !(ZERO_REG != 0 && r == 0);
        end
    end

    for (genvar r = 0; r < NREG; r++) begin : gCnt
        sb_pending_cnt #(
            .CNT_W (CNT_W),
            .DEC_W (DEC_W)
        ) uCnt (
            .clk       (clk),
            .reset     (reset),
            .inc       (incVec[r]),
            .decCnt    (decCnt[r]),
            .flush     (flush_pending),
            .cnt       (cntArr[r]),
            .eff       (effArr[r]),
            .underflow (undfVec[r])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sb_err <= 1'b0;
        end else if (|undfVec) begin
            sb_err <= 1'b1;
        end
    end

endmodule
